mux3_arbiter: RTL and testbench

//  Round-robin arbiter that shares the 8-bit 3:1 data mux (d0/d1/d2 -> y) among

---
 rtl/mux3_arbiter.sv | 111 +++++++++++
 tb/tb_mux3_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mux3_arbiter.sv
// Round-robin arbiter for an 8-bit 3:1 data mux with tenure cap and one idle turnaround cycle.
// Define MUX3_ARB_STATS_EN to add per-requester saturating grant counters (gcnt0..gcnt2).
module mux3_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] s,
  output logic       busy,
  output logic       preempt
`ifdef MUX3_ARB_STATS_EN
  ,
  output logic [7:0] gcnt0,
  output logic [7:0] gcnt1,
  output logic [7:0] gcnt2
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        last_owner;
  logic [1:0]        winner;
  logic              owner_req;

  // Later candidates overwrite earlier ones, so the loop runs lowest priority first.
  function automatic logic [1:0] pick(input logic [1:0] last, input logic [2:0] r);
    logic [1:0] cand;
    pick = last;
    for (int k = 3; k >= 1; k--) begin
      cand = 2'((int'(last) + k) % 3);
      if (r[cand]) pick = cand;
    end
  endfunction

  assign winner = pick(last_owner, req);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    owner_req = 1'b0;
    case (s)
      2'd0:    owner_req = req[0];
      2'd1:    owner_req = req[1];
      2'd2:    owner_req = req[2];
      default: owner_req = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 3'b000;
      s          <= 2'd0;
      preempt    <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= 2'd2;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= GRANT;
            gnt      <= 3'b001 << winner;
            s        <= winner;
            hold_cnt <= HOLD_W'(1);
          end
        end
        GRANT: begin
          if (owner_req && (hold_cnt < HOLD_W'(MAX_HOLD))) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end else begin
            // s is left alone so the mux keeps pointing at the last owner through the gap.
            gnt        <= 3'b000;
            last_owner <= s;
            preempt    <= owner_req;
            hold_cnt   <= '0;
            state      <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = |gnt;

`ifdef MUX3_ARB_STATS_EN
  logic [7:0] gcnt [3];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) gcnt[i] <= 8'h00;
    end else if ((state == IDLE) && (|req)) begin
      if (gcnt[winner] != 8'hFF) gcnt[winner] <= gcnt[winner] + 8'h01;
    end
  end

  assign gcnt0 = gcnt[0];
  assign gcnt1 = gcnt[1];
  assign gcnt2 = gcnt[2];
`endif

endmodule

// File: tb/tb_mux3_arbiter.sv
// Bench for mux3_arbiter: vector table, tenure/rotation sequence, random run against a
// cycle-level reference model for MAX_HOLD=8 and MAX_HOLD=1; grant counters when MUX3_ARB_STATS_EN.
module tb_mux3_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;

  logic [2:0] gnt_a, gnt_b;
  logic [1:0] s_a, s_b;
  logic       busy_a, busy_b, pre_a, pre_b;
`ifdef MUX3_ARB_STATS_EN
  logic [7:0] gc0_a, gc1_a, gc2_a, gc0_b, gc1_b, gc2_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux3_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_a), .s(s_a), .busy(busy_a), .preempt(pre_a)
`ifdef MUX3_ARB_STATS_EN
    , .gcnt0(gc0_a), .gcnt1(gc1_a), .gcnt2(gc2_a)
`endif
  );

  mux3_arbiter #(.MAX_HOLD(1), .HOLD_W(1)) u_dut_b (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_b), .s(s_b), .busy(busy_b), .preempt(pre_b)
`ifdef MUX3_ARB_STATS_EN
    , .gcnt0(gc0_b), .gcnt1(gc1_b), .gcnt2(gc2_b)
`endif
  );

  // Reference model: owner index (-1 = nobody), cycles held, pending gap cycles.
  int m_max [2] = '{8, 1};
  int m_owner [2];
  int m_tenure [2];
  int m_gap [2];
  int m_last [2];
  int m_sel [2];
  int m_pre [2];

  typedef struct {
    bit         rst;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] s;
    bit         busy;
    bit         pre;
  } vec_t;

  vec_t tbl [23];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input int i, input bit rs, input logic [2:0] r);
    bit found;
    int c;
    if (rs) begin
      m_owner[i] = -1; m_tenure[i] = 0; m_gap[i] = 0;
      m_last[i] = 2; m_sel[i] = 0; m_pre[i] = 0;
      return;
    end
    m_pre[i] = 0;
    if (m_owner[i] >= 0) begin
      if (r[m_owner[i]] && m_tenure[i] < m_max[i]) begin
        m_tenure[i]++;
      end else begin
        m_pre[i]   = r[m_owner[i]] ? 1 : 0;
        m_last[i]  = m_owner[i];
        m_owner[i] = -1;
        m_gap[i]   = 1;
      end
    end else if (m_gap[i] > 0) begin
      m_gap[i]--;
    end else if (r != 3'b000) begin
      found = 0;
      for (int k = 1; k <= 3; k++) begin
        c = (m_last[i] + k) % 3;
        if (!found && r[c]) begin
          found = 1;
          m_owner[i] = c;
        end
      end
      m_tenure[i] = 1;
      m_sel[i]    = m_owner[i];
    end
  endtask

  function automatic int model_gnt(input int i);
    return (m_owner[i] >= 0) ? (1 << m_owner[i]) : 0;
  endfunction

  task automatic check_model(input string tag);
    check({tag, "_a_gnt"},  int'(gnt_a),  model_gnt(0));
    check({tag, "_a_s"},    int'(s_a),    m_sel[0]);
    check({tag, "_a_busy"}, int'(busy_a), (m_owner[0] >= 0) ? 1 : 0);
    check({tag, "_a_pre"},  int'(pre_a),  m_pre[0]);
    check({tag, "_b_gnt"},  int'(gnt_b),  model_gnt(1));
    check({tag, "_b_s"},    int'(s_b),    m_sel[1]);
    check({tag, "_b_busy"}, int'(busy_b), (m_owner[1] >= 0) ? 1 : 0);
    check({tag, "_b_pre"},  int'(pre_b),  m_pre[1]);
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after the next edge.
  task automatic step(input bit rs, input logic [2:0] r, input string tag);
    rst = rs;
    req = r;
    @(posedge clk);
    model_edge(0, rs, r);
    model_edge(1, rs, r);
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [2:0] r;
    bit         rs;
    int         seq [4] = '{0, 1, 2, 0};

    //          rst  req     gnt     s      busy pre
    tbl[0]  = '{1, 3'b111, 3'b000, 2'd0, 0, 0};  // reset held with all requests
    tbl[1]  = '{1, 3'b111, 3'b000, 2'd0, 0, 0};
    tbl[2]  = '{0, 3'b001, 3'b001, 2'd0, 1, 0};  // req0 granted after one cycle
    tbl[3]  = '{0, 3'b001, 3'b001, 2'd0, 1, 0};
    tbl[4]  = '{0, 3'b001, 3'b001, 2'd0, 1, 0};
    tbl[5]  = '{0, 3'b000, 3'b000, 2'd0, 0, 0};  // voluntary release, no preempt
    tbl[6]  = '{0, 3'b000, 3'b000, 2'd0, 0, 0};
    tbl[7]  = '{0, 3'b010, 3'b010, 2'd1, 1, 0};
    tbl[8]  = '{0, 3'b111, 3'b010, 2'd1, 1, 0};  // others never shorten tenure
    tbl[9]  = '{0, 3'b101, 3'b000, 2'd1, 0, 0};  // owner 1 drops, s held in gap
    tbl[10] = '{0, 3'b101, 3'b000, 2'd1, 0, 0};
    tbl[11] = '{0, 3'b101, 3'b100, 2'd2, 1, 0};  // 2 wins over 0 after owner 1
    tbl[12] = '{0, 3'b001, 3'b000, 2'd2, 0, 0};
    tbl[13] = '{0, 3'b001, 3'b000, 2'd2, 0, 0};
    tbl[14] = '{0, 3'b001, 3'b001, 2'd0, 1, 0};  // then 0
    tbl[15] = '{0, 3'b000, 3'b000, 2'd0, 0, 0};
    tbl[16] = '{0, 3'b010, 3'b000, 2'd0, 0, 0};
    tbl[17] = '{0, 3'b010, 3'b010, 2'd1, 1, 0};
    tbl[18] = '{0, 3'b111, 3'b010, 2'd1, 1, 0};
    tbl[19] = '{1, 3'b111, 3'b000, 2'd0, 0, 0};  // reset mid-tenure
    tbl[20] = '{0, 3'b111, 3'b001, 2'd0, 1, 0};  // first grant after reset goes to 0
    tbl[21] = '{0, 3'b000, 3'b000, 2'd0, 0, 0};
    tbl[22] = '{0, 3'b000, 3'b000, 2'd0, 0, 0};

    for (int i = 0; i < 23; i++) begin
      step(tbl[i].rst, tbl[i].req, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_gnt", i),  int'(gnt_a),  int'(tbl[i].gnt));
      check($sformatf("vec%0d_s", i),    int'(s_a),    int'(tbl[i].s));
      check($sformatf("vec%0d_busy", i), int'(busy_a), int'(tbl[i].busy));
      check($sformatf("vec%0d_pre", i),  int'(pre_a),  int'(tbl[i].pre));
    end

    // Full contention: owners rotate 0,1,2,0, each capped at 8 cycles then preempted.
    step(1'b1, 3'b111, "rot_rst");
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < 8; c++) begin
        step(1'b0, 3'b111, $sformatf("rot%0d_c%0d", n, c));
        check($sformatf("rot%0d_c%0d_gnt", n, c), int'(gnt_a), 1 << seq[n]);
        check($sformatf("rot%0d_c%0d_s", n, c),   int'(s_a),   seq[n]);
      end
      step(1'b0, 3'b111, $sformatf("rot%0d_rel", n));
      check($sformatf("rot%0d_rel_gnt", n), int'(gnt_a), 0);
      check($sformatf("rot%0d_rel_pre", n), int'(pre_a), 1);
      step(1'b0, 3'b111, $sformatf("rot%0d_gap", n));
      check($sformatf("rot%0d_gap_gnt", n), int'(gnt_a), 0);
      check($sformatf("rot%0d_gap_pre", n), int'(pre_a), 0);
      check($sformatf("rot%0d_gap_s", n),   int'(s_a),   seq[n]);
    end

    // Random traffic: requests tend to persist so tenures reach the cap.
    r = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 25) r = 3'($urandom_range(0, 7));
      rs = ($urandom_range(0, 199) == 0);
      step(rs, r, $sformatf("rnd%0d", i));
    end

`ifdef MUX3_ARB_STATS_EN
    step(1'b1, 3'b000, "st_rst");
    check("st_rst_gcnt0", int'(gc0_a), 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b001, "st_g0");
      step(1'b0, 3'b000, "st_r0");
      step(1'b0, 3'b000, "st_i0");
    end
    step(1'b0, 3'b100, "st_g2");
    step(1'b0, 3'b000, "st_r2");
    step(1'b0, 3'b000, "st_i2");
    check("st_a_gcnt0", int'(gc0_a), 3);
    check("st_a_gcnt1", int'(gc1_a), 0);
    check("st_a_gcnt2", int'(gc2_a), 1);
    check("st_b_gcnt0", int'(gc0_b), 3);
    check("st_b_gcnt1", int'(gc1_b), 0);
    check("st_b_gcnt2", int'(gc2_b), 1);
    step(1'b1, 3'b000, "sat_rst");
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 3'b001, "sat_g");
      step(1'b0, 3'b000, "sat_r");
      step(1'b0, 3'b000, "sat_i");
    end
    check("sat_a_gcnt0", int'(gc0_a), 255);
    check("sat_b_gcnt0", int'(gc0_b), 255);
    check("sat_a_gcnt2", int'(gc2_a), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
